// File: rtl/guess_ctrl.sv
// Number-guessing controller wrapped around an external magnitude comparator.
// It registers the secret and the guesses as comparator operands and turns the sampled flags into hints and a verdict.
module guess_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_secret,
  input  logic             guess_valid,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] num1,
  output logic [WIDTH-1:0] num2,
  input  logic             lt,
  input  logic             gt,
  input  logic             eq,
  output logic             ready,
  output logic             hint_high,
  output logic             hint_low,
  output logic             win,
  output logic             lose,
  output logic [3:0]       tries,
  output logic             cmp_err,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    EVAL  = 3'd2,
    WON   = 3'd3,
    LOST  = 3'd4
  } state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  state_t           state_q;
  logic [WIDTH-1:0] num1_q, num2_q;
  logic             ready_q, hint_high_q, hint_low_q, win_q, lose_q, cmp_err_q;
  logic [3:0]       tries_q, tries_d;
  logic [2:0]       cmp_code;
  logic             cmp_illegal;

  assign tries_d     = tries_q + 4'd1;
  assign cmp_code    = {lt, gt, eq};
  assign cmp_illegal = !((cmp_code == 3'b100) || (cmp_code == 3'b010) || (cmp_code == 3'b001));

  // Handshake: a guess transfers on a rising edge where guess_valid and ready are both high
  // and set_secret is low; guess_valid with ready low is dropped, not held pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num1_q      <= '0;
      num2_q      <= '0;
      tries_q     <= 4'd0;
      ready_q     <= 1'b0;
      hint_high_q <= 1'b0;
      hint_low_q  <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      cmp_err_q   <= 1'b0;
    end else if (set_secret) begin
      state_q     <= READY;
      num1_q      <= '0;
      num2_q      <= din;
      tries_q     <= 4'd0;
      ready_q     <= 1'b1;
      hint_high_q <= 1'b0;
      hint_low_q  <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      cmp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        READY: begin
          if (guess_valid) begin
            num1_q  <= din;
            state_q <= EVAL;
            ready_q <= 1'b0;
          end
        end
        EVAL: begin
          tries_q <= tries_d;
          if (cmp_illegal) cmp_err_q <= 1'b1;
          if (eq) begin
            win_q       <= 1'b1;
            hint_high_q <= 1'b0;
            hint_low_q  <= 1'b0;
            state_q     <= WON;
            ready_q     <= 1'b0;
          end else begin
            // No flag at all counts as a miss with neither hint.
            hint_high_q <= lt;
            hint_low_q  <= !lt && gt;
            if (tries_d == MAX_T) begin
              lose_q  <= 1'b1;
              state_q <= LOST;
              ready_q <= 1'b0;
            end else begin
              state_q <= READY;
              ready_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign num1      = num1_q;
  assign num2      = num2_q;
  assign ready     = ready_q;
  assign hint_high = hint_high_q;
  assign hint_low  = hint_low_q;
  assign win       = win_q;
  assign lose      = lose_q;
  assign tries     = tries_q;
  assign cmp_err   = cmp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_guess_ctrl.sv
// Directed bench for guess_ctrl with a behavioural comparator that the bench can override.
module tb_guess_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_WON   = 3'd3;
  localparam logic [2:0] S_LOST  = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       set_secret = 1'b0;
  logic       guess_valid = 1'b0;
  logic [3:0] din = 4'd0;
  logic [3:0] num1, num2, tries;
  logic       lt, gt, eq;
  logic       ready, hint_high, hint_low, win, lose, cmp_err;
  logic [2:0] dbg_state;

  // comparator model with override
  logic force_cmp = 1'b0;
  logic f_lt = 1'b0, f_gt = 1'b0, f_eq = 1'b0;
  assign lt = force_cmp ? f_lt : (num1 <  num2);
  assign gt = force_cmp ? f_gt : (num1 >  num2);
  assign eq = force_cmp ? f_eq : (num1 == num2);

  guess_ctrl #(.WIDTH(4), .MAX_TRIES(4)) dut (
    .clk(clk), .rst_n(rst_n), .set_secret(set_secret), .guess_valid(guess_valid),
    .din(din), .num1(num1), .num2(num2), .lt(lt), .gt(gt), .eq(eq),
    .ready(ready), .hint_high(hint_high), .hint_low(hint_low), .win(win),
    .lose(lose), .tries(tries), .cmp_err(cmp_err), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [9:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [9:0] pk(input logic hh, input logic hl, input logic w,
                                    input logic l, input logic r, input logic [3:0] t,
                                    input logic e);
    return {hh, hl, w, l, r, t, e};
  endfunction

  function automatic logic [9:0] obs_pk();
    return {hint_high, hint_low, win, lose, ready, tries, cmp_err};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic load_secret(input logic [3:0] v);
    @(negedge clk);
    din = v;
    set_secret = 1'b1;
    @(negedge clk);
    set_secret = 1'b0;
  endtask

  task automatic do_guess(input string tag, input logic [3:0] g, input logic [9:0] exp);
    logic [9:0] e;
    @(negedge clk);
    din = g;
    guess_valid = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(obs_pk()), 32'(e));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(obs_pk()), 32'(pk(0,0,0,0,0,4'd0,0)));
    check("reset_num1", 32'(num1), 32'd0);
    check("reset_num2", 32'(num2), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;

    // game 1: secret 3
    load_secret(4'd3);
    check("g1_num2", 32'(num2), 32'd3);
    check("g1_num1", 32'(num1), 32'd0);
    check("g1_loaded", 32'(obs_pk()), 32'(pk(0,0,0,0,1,4'd0,0)));
    do_guess("g1_guess0", 4'd0, pk(1,0,0,0,1,4'd1,0));
    do_guess("g1_guess4", 4'd4, pk(0,1,0,0,1,4'd2,0));
    do_guess("g1_guess3", 4'd3, pk(0,0,1,0,0,4'd3,0));
    check("g1_won_state", 32'(dbg_state), 32'(S_WON));
    @(negedge clk);
    din = 4'd5;
    guess_valid = 1'b1;
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
    check("g1_ignored", 32'(obs_pk()), 32'(pk(0,0,1,0,0,4'd3,0)));
    check("g1_num1_hold", 32'(num1), 32'd3);

    // game 2: secret 6, exhaust tries
    load_secret(4'd6);
    do_guess("g2_guess7", 4'd7, pk(0,1,0,0,1,4'd1,0));
    do_guess("g2_guess0", 4'd0, pk(1,0,0,0,1,4'd2,0));
    do_guess("g2_guess1", 4'd1, pk(1,0,0,0,1,4'd3,0));
    do_guess("g2_guess2", 4'd2, pk(1,0,0,1,0,4'd4,0));
    check("g2_lost_state", 32'(dbg_state), 32'(S_LOST));
    load_secret(4'd7);
    check("g3_new_game", 32'(obs_pk()), 32'(pk(0,0,0,0,1,4'd0,0)));

    // guess_valid in IDLE, then together with set_secret
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    din = 4'd9;
    guess_valid = 1'b1;
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
    check("idle_ignore_state", 32'(dbg_state), 32'(S_IDLE));
    check("idle_ignore_num1", 32'(num1), 32'd0);
    din = 4'd5;
    set_secret = 1'b1;
    guess_valid = 1'b1;
    @(negedge clk);
    set_secret = 1'b0;
    guess_valid = 1'b0;
    check("both_num2", 32'(num2), 32'd5);
    check("both_num1", 32'(num1), 32'd0);
    check("both_outputs", 32'(obs_pk()), 32'(pk(0,0,0,0,1,4'd0,0)));
    @(negedge clk);
    check("both_no_eval", 32'(dbg_state), 32'(S_READY));

    // illegal comparator codes
    force_cmp = 1'b1; f_lt = 1'b1; f_gt = 1'b1; f_eq = 1'b0;
    do_guess("err_lt_gt", 4'd2, pk(1,0,0,0,1,4'd1,1));
    force_cmp = 1'b0;
    do_guess("err_sticky", 4'd9, pk(0,1,0,0,1,4'd2,1));
    load_secret(4'd5);
    check("err_cleared", 32'(obs_pk()), 32'(pk(0,0,0,0,1,4'd0,0)));
    force_cmp = 1'b1; f_lt = 1'b0; f_gt = 1'b0; f_eq = 1'b0;
    do_guess("err_none", 4'd5, pk(0,0,0,0,1,4'd1,1));
    force_cmp = 1'b0;

    // asynchronous reset during EVAL
    @(negedge clk);
    din = 4'd1;
    guess_valid = 1'b1;
    @(posedge clk);
    #2;
    guess_valid = 1'b0;
    check("mid_eval_state", 32'(dbg_state), 32'(S_EVAL));
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'(obs_pk()), 32'(pk(0,0,0,0,0,4'd0,0)));
    check("async_rst_nums", 32'({num1, num2}), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    din = 4'd4;
    guess_valid = 1'b1;
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ignore", 32'({dbg_state, num1, tries}), 32'({S_IDLE, 4'd0, 4'd0}));

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
